nrisc_run_ctrl: RTL
===================

// Module: nrisc_run_ctrl
// PURPOSE
//  Parametrised run controller for nRisc simulation and bring-up.
//  - Streams a program into instruction memory over a valid/ready handshake.
//  - Releases the core and counts cycles and register/memory events.
//  - Ends the run on halt (PC stuck) or on a cycle limit.
//  - Sits between the bench or host and the core plus its memories.
//  Replaces the free-running harness, which had no reset, no loader and no stop.
// PARAMETERS
//  DATA_W      8    width of instruction words on the load stream and the IMEM write port
//  ADDR_W      8    PC / IMEM address width
//  IMEM_DEPTH  256  instruction words accepted before overflow (<= 2**ADDR_W)
//  HALT_CYCLES 4    consecutive identical-PC cycles that mean halt (>= 1)
//  CNT_W       32   width of the cycle and event counters
// PORTS
//  Clock       in   1        single clock; all state changes on posedge
//  Reset       in   1        synchronous, active-high
//  Start       in   1        1-cycle pulse; begins load (IDLE/DONE only)
//  MaxCycles   in   CNT_W    run cycle limit; 0 = unlimited; sampled on Start
//  LoadValid   in   1        program word valid
//  LoadReady   out  1        controller accepts word; transfer = LoadValid & LoadReady
//  LoadData    in   DATA_W   program word
//  LoadLast    in   1        final word of program, qualified by the transfer
//  ImemWrEn    out  1        IMEM write strobe (registered)
//  ImemWrAddr  out  ADDR_W   IMEM write address
//  ImemWrData  out  DATA_W   IMEM write data
//  CpuReset    out  1        holds the core in reset
//  CpuEnable   out  1        core clock enable
//  SaidaPC     in   ADDR_W   core PC
//  EscReg      in   1        core register-write strobe
//  EscMem      in   1        core memory-write strobe
//  LerMem      in   1        core memory-read strobe
//  Done        out  1        level; run finished (any cause)
//  Timeout     out  1        run ended on MaxCycles
//  Overflow    out  1        program exceeded IMEM_DEPTH
//  ProgLen     out  ADDR_W+1 words written in the last load
//  CycleCount  out  CNT_W    cycles spent in RUN
//  RegWrites   out  CNT_W    EscReg count during RUN
//  MemWrites   out  CNT_W    EscMem count during RUN
//  MemReads    out  CNT_W    LerMem count during RUN
// BEHAVIOUR
//  Reset values (next edge, from any state):
//  - State = IDLE, CpuReset = 1.
//  - All other outputs, counters and flags = 0.
//  - IMEM contents are not cleared.
//  FSM: IDLE -> LOAD -> RUN -> DONE; DONE -> LOAD on Start. Start is ignored in LOAD and RUN.
//  IDLE:
//  - CpuReset = 1, CpuEnable = 0, LoadReady = 0.
//  - Start: clear all counters and flags, set ProgLen = 0, latch MaxCycles, go to LOAD.
//  LOAD:
//  - LoadReady = 1, CpuReset = 1.
//  - Each transfer: next cycle ImemWrEn = 1 with ImemWrAddr = ProgLen and ImemWrData = LoadData;
//    then ProgLen increments.
//  - Transfer with LoadLast: the word is written, LoadReady drops the next cycle, go to RUN.
//  - Transfer while ProgLen == IMEM_DEPTH: word is not written; set Overflow and Done; go to DONE.
//    The core is never released.
//  RUN:
//  - CpuReset = 0, CpuEnable = 1.
//  - CycleCount increments every cycle.
//  - Each event counter increments in any cycle where its strobe is high.
//  - All counters saturate at all-ones; they never wrap.
//  - Halt detect:
//    - PrevPC and StableCnt are cleared on entry.
//    - The first RUN cycle only loads PrevPC.
//    - After that: SaidaPC == PrevPC increments StableCnt; otherwise StableCnt is cleared.
//    - StableCnt reaching HALT_CYCLES -> DONE.
//  - Limit: latched MaxCycles != 0 and CycleCount + 1 == MaxCycles in this cycle -> DONE, Timeout = 1.
//  - Halt and limit on the same cycle: halt wins, Timeout = 0.
//  DONE:
//  - Done = 1, CpuEnable = 0, CpuReset = 0 (core state frozen for inspection).
//  - All counters and flags hold their values.
//  - Start clears the flags and counters and goes to LOAD.
//  Latency:
//  - IMEM write lands 1 cycle after its transfer.
//  - The core runs from the cycle after the LoadLast write.
//  - Done rises 1 cycle after the terminating condition.
// TESTING
//  1. Reset mid-RUN -> next cycle CpuReset = 1, CpuEnable = 0, all counters = 0.
//     A new Start reloads correctly.
//  2. Load 5 words 0x11..0x15 with LoadLast on the 5th, LoadValid toggled every other cycle
//     -> IMEM addresses 0..4 get 0x11..0x15, ProgLen = 5, RUN entered.
//  3. Program ends in branch-to-self at PC 0x04, HALT_CYCLES = 4
//     -> Done once PC holds 4 cycles, Timeout = 0, CycleCount matches the bench model.
//  4. Endless loop, MaxCycles = 100 -> Done with Timeout = 1 and CycleCount = 100.
//     Rerun with MaxCycles = 0 -> no timeout before 10000 cycles.
//  5. IMEM_DEPTH = 4, stream 5 words with no LoadLast -> Overflow = 1, ProgLen = 4,
//     5th word not written, CpuReset stays 1.
//  6. Strobe counts: EscReg forced high for 10 RUN cycles, EscMem for 3, LerMem for 2
//     -> RegWrites = 10, MemWrites = 3, MemReads = 2.
//     Strobes during LOAD are not counted.

Source files
------------

// File: rtl/nrisc_run_ctrl_if.sv
// rtl/nrisc_run_ctrl_if.sv - program load stream and IMEM write port of the nRisc run controller
interface nrisc_run_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              LoadValid;
    logic              LoadReady;
    logic [DATA_W-1:0] LoadData;
    logic              LoadLast;
    logic              ImemWrEn;
    logic [ADDR_W-1:0] ImemWrAddr;
    logic [DATA_W-1:0] ImemWrData;

    modport master (
        output LoadValid, LoadData, LoadLast,
        input  LoadReady, ImemWrEn, ImemWrAddr, ImemWrData
    );

    modport slave (
        input  LoadValid, LoadData, LoadLast,
        output LoadReady, ImemWrEn, ImemWrAddr, ImemWrData
    );
endinterface

// File: rtl/nrisc_run_ctrl.sv
// rtl/nrisc_run_ctrl.sv - nRisc run controller: program loader, core release, event counters, halt/limit stop
module nrisc_run_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int IMEM_DEPTH  = 256,
    parameter int HALT_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    nrisc_run_ctrl_if.slave   loadBus,
    input  logic              Start,
    input  logic [CNT_W-1:0]  MaxCycles,
    output logic              CpuReset,
    output logic              CpuEnable,
    input  logic [ADDR_W-1:0] SaidaPC,
    input  logic              EscReg,
    input  logic              EscMem,
    input  logic              LerMem,
    output logic              Done,
    output logic              Timeout,
    output logic              Overflow,
    output logic [ADDR_W:0]   ProgLen,
    output logic [CNT_W-1:0]  CycleCount,
    output logic [CNT_W-1:0]  RegWrites,
    output logic [CNT_W-1:0]  MemWrites,
    output logic [CNT_W-1:0]  MemReads
);
    localparam int STAB_W = $clog2(HALT_CYCLES + 1);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(IMEM_DEPTH);
    localparam logic [STAB_W-1:0] HALT_L  = STAB_W'(HALT_CYCLES);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  maxLatched;
    logic              lastSeen;
    logic              firstRun;
    logic [ADDR_W-1:0] prevPC;
    logic [STAB_W-1:0] stableCnt;

    logic              transfer;
    logic [CNT_W:0]    cycPlusOne;
    logic [STAB_W-1:0] stableNext;
    logic              haltNow;
    logic              limitNow;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    assign transfer   = loadBus.LoadValid & loadBus.LoadReady;
    assign cycPlusOne = {1'b0, CycleCount} + 1'b1;

    // The first RUN cycle only captures the PC, so it never counts as a repeat.
    always_comb begin
        stableNext = '0;
        if (!firstRun && (SaidaPC == prevPC)) begin
            stableNext = stableCnt + 1'b1;
        end
        haltNow  = (stableNext == HALT_L);
        limitNow = (maxLatched != '0) && (cycPlusOne == {1'b0, maxLatched});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            CpuReset           <= 1'b1;
            CpuEnable          <= 1'b0;
            loadBus.LoadReady  <= 1'b0;
            loadBus.ImemWrEn   <= 1'b0;
            loadBus.ImemWrAddr <= '0;
            loadBus.ImemWrData <= '0;
            Done               <= 1'b0;
            Timeout            <= 1'b0;
            Overflow           <= 1'b0;
            ProgLen            <= '0;
            CycleCount         <= '0;
            RegWrites          <= '0;
            MemWrites          <= '0;
            MemReads           <= '0;
            maxLatched         <= '0;
            lastSeen           <= 1'b0;
            firstRun           <= 1'b0;
            prevPC             <= '0;
            stableCnt          <= '0;
        end else begin
            loadBus.ImemWrEn <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state             <= LOAD;
                        loadBus.LoadReady <= 1'b1;
                        CpuReset          <= 1'b1;
                        CpuEnable         <= 1'b0;
                        Done              <= 1'b0;
                        Timeout           <= 1'b0;
                        Overflow          <= 1'b0;
                        ProgLen           <= '0;
                        CycleCount        <= '0;
                        RegWrites         <= '0;
                        MemWrites         <= '0;
                        MemReads          <= '0;
                        maxLatched        <= MaxCycles;
                        lastSeen          <= 1'b0;
                    end
                end
                LOAD: begin
                    // Release the core only once the final word has reached IMEM.
                    if (lastSeen) begin
                        state     <= RUN;
                        CpuReset  <= 1'b0;
                        CpuEnable <= 1'b1;
                        firstRun  <= 1'b1;
                        prevPC    <= '0;
                        stableCnt <= '0;
                    end else if (transfer) begin
                        if (ProgLen == DEPTH_L) begin
                            state             <= DONE;
                            Overflow          <= 1'b1;
                            Done              <= 1'b1;
                            loadBus.LoadReady <= 1'b0;
                        end else begin
                            loadBus.ImemWrEn   <= 1'b1;
                            loadBus.ImemWrAddr <= ProgLen[ADDR_W-1:0];
                            loadBus.ImemWrData <= loadBus.LoadData;
                            ProgLen            <= ProgLen + 1'b1;
                            if (loadBus.LoadLast) begin
                                loadBus.LoadReady <= 1'b0;
                                lastSeen          <= 1'b1;
                            end
                        end
                    end
                end
                RUN: begin
                    CycleCount <= satInc(CycleCount, 1'b1);
                    RegWrites  <= satInc(RegWrites, EscReg);
                    MemWrites  <= satInc(MemWrites, EscMem);
                    MemReads   <= satInc(MemReads, LerMem);
                    prevPC     <= SaidaPC;
                    firstRun   <= 1'b0;
                    stableCnt  <= stableNext;
                    if (haltNow || limitNow) begin
                        state     <= DONE;
                        Done      <= 1'b1;
                        CpuEnable <= 1'b0;
                        Timeout   <= !haltNow;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
